// File: rtl/sorted_insert.sv
`default_nettype none
// ============================================================================
//  Module      : sorted_insert
//  Description : Keeps an ascending array in an internal dual-port RAM.
//                Each insert request shifts larger entries up one slot and
//                writes the new value into the gap. A second, read-only
//                port gives the search engine registered 1-cycle reads.
//  Revision    : 1.0  initial release
// ============================================================================
module sorted_insert #(
    parameter int SIZE = 32,
    parameter int AW   = 5,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] a,
    input  logic          Start,
    input  logic          Clear,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          Busy,
    output logic          Done,
    output logic          Ok,
    output logic [AW-1:0] Loc,
    output logic [AW:0]   Count
);

    // Engine states
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CHECK = 3'd1;
    localparam logic [2:0] c_CMP   = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    // Count and idx are one bit wider than an address so "full" is representable
    localparam logic [AW:0]   c_SIZE_CNT = (AW+1)'(SIZE);
    localparam logic [AW:0]   c_ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] c_ONE_ADR  = AW'(1);

    logic [DW-1:0] r_mem [SIZE];

    logic [2:0]    r_state;
    logic [DW-1:0] r_a_reg;
    logic [AW:0]   r_idx;
    logic [AW:0]   r_count;
    logic          r_ok;
    logic [AW-1:0] r_loc;
    logic [DW-1:0] r_q;
    logic [DW-1:0] r_rd_data;

    logic [AW-1:0] w_eng_raddr;
    logic          w_full;
    logic          w_shift;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    // Neighbour below the gap; only consumed when idx is non-zero
    assign w_eng_raddr = r_idx[AW-1:0] - c_ONE_ADR;
    assign w_full      = (r_count == c_SIZE_CNT);
    // Strict compare keeps equal values below the new one (stable insert)
    assign w_shift     = (r_q > r_a_reg);

    // Engine write port: shift an entry up in CMP, drop the new value in WRITE
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_idx[AW-1:0];
        w_wdata = r_a_reg;
        if (!reset) begin
            case (r_state)
                c_CMP: begin
                    if (w_shift) begin
                        w_we    = 1'b1;
                        w_wdata = r_q;
                    end
                end
                c_WRITE: begin
                    w_we = 1'b1;
                end
                default: begin
                    w_we = 1'b0;
                end
            endcase
        end
    end

    // RAM write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Engine read port: address presented in CHECK, data used in CMP
    always_ff @(posedge clk) begin
        r_q <= r_mem[w_eng_raddr];
    end

    // Search read port: registered, returns old data on a write collision
    always_ff @(posedge clk) begin
        r_rd_data <= r_mem[rd_addr];
    end

    // Insert engine control and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_a_reg <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_ok    <= 1'b0;
            r_loc   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (Clear) begin
                        r_count <= '0;
                    end else if (Start) begin
                        if (w_full) begin
                            r_ok    <= 1'b0;
                            r_loc   <= '0;
                            r_state <= c_DONE;
                        end else begin
                            r_a_reg <= a;
                            r_idx   <= r_count;
                            r_state <= c_CHECK;
                        end
                    end
                end
                c_CHECK: begin
                    if (r_idx == '0) begin
                        r_state <= c_WRITE;
                    end else begin
                        r_state <= c_CMP;
                    end
                end
                c_CMP: begin
                    if (w_shift) begin
                        r_idx   <= r_idx - c_ONE_CNT;
                        r_state <= c_CHECK;
                    end else begin
                        r_state <= c_WRITE;
                    end
                end
                c_WRITE: begin
                    r_loc   <= r_idx[AW-1:0];
                    r_ok    <= 1'b1;
                    r_count <= r_count + c_ONE_CNT;
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign Busy    = (r_state != c_IDLE);
    assign Done    = (r_state == c_DONE);
    assign Ok      = r_ok;
    assign Loc     = r_loc;
    assign Count   = r_count;
    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_sorted_insert.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sorted_insert
//  Description : Self-checking bench for sorted_insert. A sorted queue holds
//                the expected array; positions and latencies come from it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sorted_insert;

    localparam int SIZE = 32;
    localparam int AW   = 5;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] a;
    logic          Start;
    logic          Clear;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          Busy;
    logic          Done;
    logic          Ok;
    logic [AW-1:0] Loc;
    logic [AW:0]   Count;

    int checks   = 0;
    int failures = 0;

    bit [7:0] model[$];

    sorted_insert #(.SIZE(SIZE), .AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .Start   (Start),
        .Clear   (Clear),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .Busy    (Busy),
        .Done    (Done),
        .Ok      (Ok),
        .Loc     (Loc),
        .Count   (Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One insert request; expected position and latency come from the queue
    task automatic insert(input bit [7:0] v, input bit disturb);
        int  n, p, exp_lat, lat;
        bit  full;
        n    = model.size();
        full = (n == SIZE);
        p    = 0;
        if (!full) begin
            while (p < n && model[p] <= v) p++;
        end
        exp_lat = full ? 1 : 2 * (n - p) + 3 + ((p > 0) ? 1 : 0);
        @(negedge clk);
        a = v; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        lat   = 1;
        if (disturb) begin
            Start = 1'b1; Clear = 1'b1; a = ~v;
        end
        while (Done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            Start = 1'b0; Clear = 1'b0;
        end
        Start = 1'b0; Clear = 1'b0;
        check("latency", lat, exp_lat);
        check("ok", Ok, full ? 0 : 1);
        check("loc", Loc, full ? 0 : p);
        if (!full) model.insert(p, v);
        check("count", Count, model.size());
        @(negedge clk);
        check("done_pulse", Done, 0);
        check("busy_idle", Busy, 0);
    endtask

    task automatic readback();
        for (int i = 0; i < model.size(); i++) begin
            @(negedge clk);
            rd_addr = i[AW-1:0];
            @(negedge clk);
            check("rd_data", rd_data, model[i]);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        Clear = 1'b1;
        @(negedge clk);
        Clear = 1'b0;
        check("clear_count", Count, 0);
        model.delete();
    endtask

    task automatic watch_no_done(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (Done === 1'b1 || Busy === 1'b1) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; Clear = 1'b0; a = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_ok", Ok, 0);
        check("rst_loc", Loc, 0);
        check("rst_count", Count, 0);

        // Single insert into an empty array
        insert(8'h40, 1'b0);
        readback();

        // Mixed positions: empty, append, middle, front
        do_clear();
        insert(8'h10, 1'b0);
        insert(8'h30, 1'b0);
        insert(8'h20, 1'b0);
        insert(8'h05, 1'b0);
        readback();

        // Duplicate lands above its equal
        do_clear();
        insert(8'h10, 1'b0);
        insert(8'h20, 1'b0);
        insert(8'h30, 1'b0);
        insert(8'h20, 1'b0);
        readback();

        // Fill to capacity, then a rejected request
        do_clear();
        for (int i = 0; i < SIZE; i++) insert(8'(i), 1'b0);
        insert(8'h80, 1'b0);
        readback();

        // Random values, some from a coarse set to force duplicates
        do_clear();
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) insert(8'($urandom_range(0, 7) * 32), 1'b0);
            else            insert(8'($urandom_range(0, 255)), 1'b0);
        end
        readback();

        // Reset while the engine sits in CMP
        do_clear();
        insert(8'h10, 1'b0);
        insert(8'h20, 1'b0);
        insert(8'h30, 1'b0);
        insert(8'h40, 1'b0);
        insert(8'h50, 1'b0);
        @(negedge clk);
        a = 8'h05; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("busy_check_state", Busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_count", Count, 0);
        check("abort_busy", Busy, 0);
        model.delete();
        watch_no_done("abort_no_done");
        insert(8'h77, 1'b0);
        readback();

        // Start and Clear while busy are ignored; a is re-sampled only on accept
        insert(8'h20, 1'b0);
        insert(8'h90, 1'b0);
        insert(8'h01, 1'b1);
        insert(8'h50, 1'b1);
        readback();

        // Start together with Clear in IDLE: Clear wins
        @(negedge clk);
        a = 8'h33; Start = 1'b1; Clear = 1'b1;
        @(negedge clk);
        Start = 1'b0; Clear = 1'b0;
        check("startclear_count", Count, 0);
        check("startclear_busy", Busy, 0);
        model.delete();
        watch_no_done("startclear_no_done");
        insert(8'h66, 1'b0);
        readback();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
